// File: rtl/grid_pkg.sv
// Shared grid geometry, colours and scheduler FSM encoding for the step-sequencer display path.
// The VGA block renderer imports the same constants so both sides agree on cell placement.
package grid_pkg;

  localparam int GRID_N     = 12;
  localparam int X0         = 214;
  localparam int Y0         = 32;
  localparam int PITCH      = 33;
  localparam int BLOCK_SIZE = 30;

  localparam logic COLOUR_ON  = 1'b1;  // white
  localparam logic COLOUR_OFF = 1'b0;  // blue

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic       state;
  } cell_evt_t;

  function automatic logic [9:0] cell_x(input logic [3:0] col);
    return 10'(X0 + int'(col) * PITCH);
  endfunction

  function automatic logic [8:0] cell_y(input logic [3:0] row);
    return 9'(Y0 + int'(row) * PITCH);
  endfunction

endpackage

// File: rtl/grid_draw_scheduler_if.sv
// Cell-event input and renderer handshake between sequencer/UI logic, the scheduler and the renderer.
interface grid_draw_scheduler_if;
  logic       cell_valid;
  logic [3:0] cell_row;
  logic [3:0] cell_col;
  logic       cell_state;
  logic       cell_ready;
  logic       drawing;
  logic       draw_enable;
  logic [9:0] X;
  logic [8:0] Y;
  logic       state;
  logic       busy;
  logic       dropped;

  modport slave (
    input  cell_valid, cell_row, cell_col, cell_state, drawing,
    output cell_ready, draw_enable, X, Y, state, busy, dropped
  );

  modport master (
    output cell_valid, cell_row, cell_col, cell_state, drawing,
    input  cell_ready, draw_enable, X, Y, state, busy, dropped
  );
endinterface

// File: rtl/grid_draw_scheduler_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on rdata_o whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     nReset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // A push while full is refused even if a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/grid_draw_scheduler.sv
// Buffers cell-update events and feeds them one block at a time to the VGA block renderer,
// converting grid row/col to the pixel origin of the 30x30 cell.
module grid_draw_scheduler
  import grid_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic                   CLOCK_50,
  input logic                   nReset,
  grid_draw_scheduler_if.slave  sif
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]    fsm_q, fsm_d;
  logic          seen_busy_q, seen_busy_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic          state_q, state_d;
  logic          dropped_q;

  cell_evt_t     in_evt, head_evt;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CW-1:0] fifo_count;
  logic          in_range, accepting, drop_evt;

  assign in_evt    = '{row: sif.cell_row, col: sif.cell_col, state: sif.cell_state};
  assign in_range  = (int'(sif.cell_row) < GRID_N) && (int'(sif.cell_col) < GRID_N);
  // Events during the background repaint are refused quietly; they are not counted as drops.
  assign accepting = (fsm_q != ST_INIT);
  assign fifo_push = sif.cell_valid && accepting && in_range;
  assign drop_evt  = sif.cell_valid && accepting && (fifo_full || !in_range);

  sync_fifo #(
    .WIDTH ($bits(cell_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .nReset   (nReset),
    .push_i   (fifo_push),
    .wdata_i  (in_evt),
    .pop_i    (fifo_pop),
    .rdata_o  (head_evt),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  always_comb begin
    fsm_d       = fsm_q;
    seen_busy_d = seen_busy_q;
    tmo_d       = tmo_q;
    x_d         = x_q;
    y_d         = y_q;
    state_d     = state_q;
    fifo_pop    = 1'b0;
    case (fsm_q)
      ST_INIT: begin
        if (sif.drawing) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          seen_busy_d = 1'b0;
          fsm_d       = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          x_d      = cell_x(head_evt.col);
          y_d      = cell_y(head_evt.row);
          state_d  = head_evt.state;
          fsm_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d = '0;
        fsm_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Renderer missed the pulse: re-issue after BUSY_TIMEOUT cycles with the same block.
        if (sif.drawing) begin
          fsm_d = ST_WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          fsm_d = ST_ISSUE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!sif.drawing) fsm_d = ST_GAP;
      end
      ST_GAP: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      fsm_q       <= ST_INIT;
      seen_busy_q <= 1'b0;
      tmo_q       <= '0;
      x_q         <= 10'(X0);
      y_q         <= 9'(Y0);
      state_q     <= COLOUR_ON;
      dropped_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      seen_busy_q <= seen_busy_d;
      tmo_q       <= tmo_d;
      x_q         <= x_d;
      y_q         <= y_d;
      state_q     <= state_d;
      dropped_q   <= dropped_q | drop_evt;
    end
  end

  assign sif.cell_ready  = !fifo_full && accepting;
  assign sif.draw_enable = (fsm_q == ST_ISSUE);
  assign sif.X           = x_q;
  assign sif.Y           = y_q;
  assign sif.state       = state_q;
  assign sif.busy        = (fsm_q != ST_IDLE) || (fifo_count != '0);
  assign sif.dropped     = dropped_q;

endmodule

// File: tb/tb_grid_draw_scheduler.sv
// Randomised self-checking bench: renderer model, pixel-origin reference queue and handshake timing monitor.
module tb_grid_draw_scheduler;

  logic CLOCK_50 = 1'b0;
  logic nReset;

  grid_draw_scheduler_if sif();

  grid_draw_scheduler #(
    .FIFO_DEPTH   (8),
    .BUSY_TIMEOUT (15)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .nReset   (nReset),
    .sif      (sif)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Reference model: each accepted event becomes one expected block origin.
  typedef struct { int x; int y; int st; } draw_t;
  draw_t exp_q[$];

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Renderer model
  int   rend_len  = 20;
  bit   stall     = 1'b0;
  int   init_req  = 0, init_done = 0;
  int   ign_req   = 0, ign_done  = 0;
  int   rend_cnt  = 0;
  logic drawing_r = 1'b0;
  assign sif.drawing = drawing_r;

  always @(posedge CLOCK_50) begin
    if (init_req != init_done) begin
      init_done <= init_req;
      drawing_r <= 1'b1;
      rend_cnt  <= 100;
    end else if (rend_cnt > 0) begin
      if (!stall) begin
        if (rend_cnt == 1) drawing_r <= 1'b0;
        rend_cnt <= rend_cnt - 1;
      end
    end else if (sif.draw_enable) begin
      if (ign_req != ign_done) ign_done <= ign_done + 1;
      else begin
        drawing_r <= 1'b1;
        rend_cnt  <= rend_len;
      end
    end
  end

  // Handshake monitor
  int    last_fall = -1000, last_pulse = -1000;
  int    n_pulses = 0, epoch = 0, pulse_epoch = 0;
  bit    prev_de = 1'b0, prev_ign = 1'b0, prev_drawing = 1'b0, have_cur = 1'b0;
  draw_t cur;

  always @(negedge CLOCK_50) begin
    if (prev_drawing && !sif.drawing) begin
      last_fall = cyc;
      if (have_cur && pulse_epoch == epoch) begin
        chk("hold_x", 32'(sif.X), cur.x);
        chk("hold_y", 32'(sif.Y), cur.y);
        chk("hold_state", 32'(sif.state), cur.st);
      end
      have_cur = 1'b0;
    end
    if (sif.draw_enable === 1'b1) begin
      bit ign;
      n_pulses++;
      chk("de_one_cycle", 32'(prev_de), 0);
      chk("de_gap_ge3", 32'(cyc - last_fall >= 3), 1);
      if (prev_ign) chk("retry_distance", cyc - last_pulse, 16);
      if (exp_q.size() == 0) begin
        chk("unexpected_de", 1, 0);
        prev_ign = 1'b0;
      end else begin
        chk("de_x", 32'(sif.X), exp_q[0].x);
        chk("de_y", 32'(sif.Y), exp_q[0].y);
        chk("de_state", 32'(sif.state), exp_q[0].st);
        ign = (ign_req != ign_done);
        if (!ign) begin
          cur         = exp_q.pop_front();
          pulse_epoch = epoch;
          have_cur    = 1'b1;
        end
        prev_ign = ign;
      end
      last_pulse = cyc;
    end
    prev_de      = sif.draw_enable;
    prev_drawing = sif.drawing;
  end

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic drive_evt(input int r, input int c, input int s);
    sif.cell_valid = 1'b1;
    sif.cell_row   = 4'(r);
    sif.cell_col   = 4'(c);
    sif.cell_state = 1'(s);
    tick();
    sif.cell_valid = 1'b0;
  endtask

  task automatic push_ok(input int r, input int c, input int s);
    chk("cell_ready", 32'(sif.cell_ready), 1);
    exp_q.push_back('{214 + 33 * c, 32 + 33 * r, s});
    drive_evt(r, c, s);
  endtask

  task automatic wait_drawing(input logic v, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (sif.drawing === v) return;
      tick();
    end
    chk(tag, 32'(sif.drawing), 32'(v));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && sif.busy === 1'b0) return;
      tick();
    end
    chk("idle_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_pulses >= target) return;
      tick();
    end
    chk("pulse_timeout", n_pulses, target);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"},   32'(sif.cell_ready), 0);
    chk({tag, "_de"},      32'(sif.draw_enable), 0);
    chk({tag, "_x"},       32'(sif.X), 214);
    chk({tag, "_y"},       32'(sif.Y), 32);
    chk({tag, "_state"},   32'(sif.state), 1);
    chk({tag, "_busy"},    32'(sif.busy), 1);
    chk({tag, "_dropped"}, 32'(sif.dropped), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    sif.cell_valid = 1'b0;
    sif.cell_row   = '0;
    sif.cell_col   = '0;
    sif.cell_state = 1'b0;
    nReset = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    nReset = 1'b1;
    repeat (5) tick();
    chk("init_ready", 32'(sif.cell_ready), 0);
    drive_evt(1, 1, 1);
    chk("init_no_drop", 32'(sif.dropped), 0);

    // Background repaint
    init_req++;
    wait_drawing(1'b1, 10, "init_rise");
    wait_drawing(1'b0, 200, "init_fall");
    chk("ready_at_fall", 32'(sif.cell_ready), 0);
    tick();
    chk("ready_after_fall", 32'(sif.cell_ready), 1);
    chk("init_no_de", n_pulses, 0);

    // Corner cells
    push_ok(0, 0, 1);
    wait_idle(300);
    chk("c00_x", 32'(sif.X), 214);
    chk("c00_y", 32'(sif.Y), 32);
    chk("c00_state", 32'(sif.state), 1);
    push_ok(11, 11, 0);
    wait_idle(300);
    chk("c1111_x", 32'(sif.X), 577);
    chk("c1111_y", 32'(sif.Y), 395);
    chk("c1111_state", 32'(sif.state), 0);

    // Three back-to-back events, long draws
    rend_len = 961;
    base = n_pulses;
    for (int k = 0; k < 3; k++)
      push_ok($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 1));
    wait_pulses(base + 3, 4000);
    wait_drawing(1'b1, 5, "b2b_rise");
    wait_drawing(1'b0, 1100, "b2b_fall");
    tick();
    chk("busy_in_gap", 32'(sif.busy), 1);
    tick();
    chk("busy_after_gap", 32'(sif.busy), 0);

    // Random bursts
    for (int b = 0; b < 15; b++) begin
      int n;
      rend_len = $urandom_range(3, 30);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        push_ok($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 1));
      wait_idle(600);
    end
    chk("rand_no_drop", 32'(sif.dropped), 0);

    // Stalled renderer: fill the FIFO and overflow it
    stall = 1'b1;
    rend_len = 20;
    push_ok(5, 5, 1);
    wait_drawing(1'b1, 10, "stall_rise");
    for (int k = 0; k < 8; k++)
      push_ok($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 1));
    chk("full_ready", 32'(sif.cell_ready), 0);
    chk("full_no_drop_yet", 32'(sif.dropped), 0);
    drive_evt(3, 3, 1);
    chk("drop_on_full", 32'(sif.dropped), 1);
    stall = 1'b0;
    wait_idle(2000);

    // Renderer ignores the first pulse
    ign_req++;
    push_ok(7, 2, 0);
    wait_idle(400);
    chk("retry_ign_consumed", ign_done, ign_req);

    // Reset in the middle of a draw
    rend_len = 50;
    push_ok(4, 9, 1);
    wait_drawing(1'b1, 20, "mid_rise");
    repeat (3) tick();
    nReset = 1'b0;
    epoch++;
    #1;
    check_reset_vals("midrst");
    tick();
    nReset = 1'b1;
    tick();
    chk("midrst_init_ready", 32'(sif.cell_ready), 0);
    chk("midrst_init_busy", 32'(sif.busy), 1);
    wait_drawing(1'b0, 100, "midrst_fall");
    tick();
    chk("midrst_ready", 32'(sif.cell_ready), 1);

    // Out-of-range coordinates
    base = n_pulses;
    drive_evt(12, 3, 1);
    chk("oor_row_drop", 32'(sif.dropped), 1);
    drive_evt(2, 15, 0);
    repeat (10) tick();
    chk("oor_no_de", n_pulses, base);
    chk("oor_idle", 32'(sif.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
